// File: rtl/register_file_if.sv
// Register file access bundle: write-back write port, two operand read ports,
// and the init/commit status returned by the register file.
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              regwrite;
    logic [1:0]        regdst;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_addr1;
    logic [ADDR_W-1:0] read_addr2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              ready;
    logic [ADDR_W-1:0] write_addr_out;

    modport master (
        output regwrite, regdst, rt_addr, rd_addr, write_data,
        output read_addr1, read_addr2,
        input  read_data1, read_data2, ready, write_addr_out
    );

    modport slave (
        input  regwrite, regdst, rt_addr, rd_addr, write_data,
        input  read_addr1, read_addr2,
        output read_data1, read_data2, ready, write_addr_out
    );
endinterface

// File: rtl/register_file.sv
// MIPS 32x32 register file with a post-reset clear sweep (one entry per cycle).
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through on both read ports.
module register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RA_INDEX = 31
) (
    input logic clk,
    input logic rst,
    register_file_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] wao;
    logic              run;
    logic              commit;
    logic [DATA_W-1:0] mem [DEPTH];

    assign run    = (state == RUN);
    assign commit = run && bus.regwrite && (wa != '0);

    always_comb begin
        wa = bus.rt_addr;
        unique case (1'b1)
            (bus.regdst == 2'b01): wa = bus.rd_addr;
            (bus.regdst == 2'b10): wa = RA_INDEX[ADDR_W-1:0];
            default:               wa = bus.rt_addr;
        endcase
    end

    // Counter parks on its last index; only rst starts another sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
            wao   <= '0;
        end else if (!run) begin
            if (&cnt) state <= RUN;
            else      cnt   <= cnt + 1'b1;
        end else if (commit) begin
            wao <= wa;
        end
    end

    // Storage has no reset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run)        mem[cnt] <= '0;
            else if (commit) mem[wa]  <= bus.write_data;
        end
    end

    always_comb begin
        bus.read_data1 = '0;
        if (run && bus.read_addr1 != '0) begin
            bus.read_data1 = mem[bus.read_addr1];
`ifdef REGFILE_BYPASS_EN
            if (commit && wa == bus.read_addr1) bus.read_data1 = bus.write_data;
`endif
        end
    end

    always_comb begin
        bus.read_data2 = '0;
        if (run && bus.read_addr2 != '0) begin
            bus.read_data2 = mem[bus.read_addr2];
`ifdef REGFILE_BYPASS_EN
            if (commit && wa == bus.read_addr2) bus.read_data2 = bus.write_data;
`endif
        end
    end

    assign bus.ready          = run;
    assign bus.write_addr_out = wao;
endmodule

// File: tb/tb_register_file.sv
// Randomized bench for register_file against an array-based reference model.
// Directed sequences cover init timing, dest select, $zero and hazards.
module tb_register_file;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    register_file #(.DATA_W(32), .ADDR_W(5), .RA_INDEX(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model [32];
    int          m_sweep;
    logic        m_ready;
    logic        m_known = 1'b0;
    logic [4:0]  m_wao;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    function automatic logic [4:0] dest(input logic [1:0] dst,
                                        input logic [4:0] rt,
                                        input logic [4:0] rd);
        if (dst == 2'b01) return rd;
        if (dst == 2'b10) return 5'd31;
        return rt;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a,
                                             input logic we,
                                             input logic [4:0] w,
                                             input logic [31:0] wd);
        if (!m_ready || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && w != 0 && w == a) return wd;
`endif
        return model[a];
    endfunction

    // One clock: drive, check reads, clock, update model, check state.
    task automatic cyc(input logic we, input logic [1:0] dst,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2);
        logic [4:0] w;
        bus.regwrite   = we;
        bus.regdst     = dst;
        bus.rt_addr    = rt;
        bus.rd_addr    = rd;
        bus.write_data = wd;
        bus.read_addr1 = ra1;
        bus.read_addr2 = ra2;
        w = dest(dst, rt, rd);
        #1;
        if (m_known) begin
            check("rd1", bus.read_data1, exp_read(ra1, we, w, wd));
            check("rd2", bus.read_data2, exp_read(ra2, we, w, wd));
        end
        @(posedge clk);
        if (rst) begin
            m_known = 1'b1;
            m_sweep = 0;
            m_ready = 1'b0;
            m_wao   = 5'd0;
        end else if (!m_ready) begin
            model[m_sweep] = 32'h0;
            m_sweep++;
            if (m_sweep == 32) m_ready = 1'b1;
        end else if (we && w != 0) begin
            model[w] = wd;
            m_wao    = w;
        end
        #1;
        if (m_known) begin
            check("ready", {31'h0, bus.ready}, {31'h0, m_ready});
            check("wao", {27'h0, bus.write_addr_out}, {27'h0, m_wao});
        end
    endtask

    task automatic idle(input logic [4:0] ra1, input logic [4:0] ra2);
        cyc(1'b1, 2'b01, 5'd0, 5'd5, 32'hDEADBEEF, ra1, ra2);
    endtask

    initial begin
        int n;
        logic [4:0] rt, rd, w;
        logic [1:0] dst;
        bus.regwrite = 1'b0;
        bus.regdst = 2'b00;
        bus.rt_addr = '0;
        bus.rd_addr = '0;
        bus.write_data = '0;
        bus.read_addr1 = '0;
        bus.read_addr2 = '0;
        @(negedge clk);

        // Reset, then sweep with a stray write request pending.
        rst = 1'b1;
        idle(5'd5, 5'd0);
        rst = 1'b0;
        n = 0;
        while (!bus.ready && n < 40) begin
            idle(5'(n), 5'd5);
            n++;
        end
        check("init_len", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

        // Destination select.
        cyc(1'b1, 2'b00, 5'd3, 5'd7, 32'h1, 5'd3, 5'd7);
        check("wao_rt", {27'h0, bus.write_addr_out}, 32'd3);
        cyc(1'b1, 2'b01, 5'd3, 5'd7, 32'h2, 5'd3, 5'd7);
        check("wao_rd", {27'h0, bus.write_addr_out}, 32'd7);
        cyc(1'b1, 2'b10, 5'd3, 5'd7, 32'h3, 5'd31, 5'd7);
        check("wao_ra", {27'h0, bus.write_addr_out}, 32'd31);
        cyc(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 5'd3, 5'd31);
        check("reg3", bus.read_data1, 32'h1);
        check("reg31", bus.read_data2, 32'h3);

        // $zero write dropped.
        cyc(1'b1, 2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        cyc(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 5'd0, 5'd7);
        check("zero", bus.read_data1, 32'h0);
        check("wao_hold", {27'h0, bus.write_addr_out}, 32'd31);

        // Same-cycle write/read hazard on reg9.
        cyc(1'b1, 2'b00, 5'd9, 5'd0, 32'hAAAA0000, 5'd9, 5'd0);
        cyc(1'b1, 2'b00, 5'd9, 5'd0, 32'h12345678, 5'd9, 5'd9);
        cyc(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 5'd9, 5'd9);
        check("haz_next", bus.read_data1, 32'h12345678);

        // regwrite low.
        cyc(1'b1, 2'b00, 5'd4, 5'd0, 32'h44444444, 5'd4, 5'd0);
        cyc(1'b0, 2'b00, 5'd4, 5'd0, 32'hCAFEF00D, 5'd4, 5'd0);
        cyc(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 5'd4, 5'd4);
        check("we_low", bus.read_data1, 32'h44444444);

        // Randomized traffic, biased toward read/write collisions.
        for (int i = 0; i < 400; i++) begin
            rt  = 5'($urandom);
            rd  = 5'($urandom);
            dst = 2'($urandom);
            w   = dest(dst, rt, rd);
            cyc(1'($urandom), dst, rt, rd, $urandom,
                ($urandom_range(0, 3) == 0) ? w : 5'($urandom),
                ($urandom_range(0, 3) == 0) ? w : 5'($urandom));
        end

        // Reset in the middle of a sweep restarts it.
        rst = 1'b1;
        idle(5'd1, 5'd2);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) idle(5'd3, 5'd4);
        rst = 1'b1;
        idle(5'd3, 5'd4);
        rst = 1'b0;
        n = 0;
        while (!bus.ready && n < 40) begin
            idle(5'd31, 5'd9);
            n++;
        end
        check("reinit_len", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) idle(5'(i), 5'd9);

        for (int i = 0; i < 100; i++) begin
            rt  = 5'($urandom);
            rd  = 5'($urandom);
            dst = 2'($urandom);
            cyc(1'($urandom), dst, rt, rd, $urandom,
                5'($urandom), dest(dst, rt, rd));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
